// File: rtl/demux1_4_16bits_reg.sv
// rtl/demux1_4_16bits_reg.sv - 1:4 registered demux with per-slot valid/ack handshake
module demux1_4_16bits_reg #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] I,
  input  logic [1:0]       S,
  input  logic             IV,
  output logic             IR,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic [3:0]       OV,
  input  logic [3:0]       ACK,
  output logic [2:0]       CNT
);

  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [3:0]       ov_q;
  logic [3:0]       ov_d;
  logic [2:0]       cnt_q;
  logic [2:0]       cnt_d;
  logic             accept;

  // IR depends only on the registered valid of the selected slot, so a
  // same-slot ACK frees the slot this edge and the write lands on the next.
  assign IR     = ~ov_q[S];
  assign accept = IV & IR;

  always_comb begin
    ov_d  = ov_q;
    cnt_d = '0;
    for (int k = 0; k < 4; k++) begin
      data_d[k] = data_q[k];
      ov_d[k]   = ov_q[k] & ~ACK[k];
      if (accept && (S == 2'(k))) begin
        data_d[k] = I;
        ov_d[k]   = 1'b1;
      end
      cnt_d = cnt_d + {2'b00, ov_d[k]};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
      ov_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
      end
      ov_q  <= ov_d;
      cnt_q <= cnt_d;
    end
  end

  assign O0  = data_q[0];
  assign O1  = data_q[1];
  assign O2  = data_q[2];
  assign O3  = data_q[3];
  assign OV  = ov_q;
  assign CNT = cnt_q;

endmodule

// File: tb/tb_demux1_4_16bits_reg.sv
// tb/tb_demux1_4_16bits_reg.sv - table-driven bench for demux1_4_16bits_reg
module tb_demux1_4_16bits_reg;

  logic        CLK;
  logic        RST_N;
  logic [15:0] I;
  logic [1:0]  S;
  logic        IV;
  logic        IR;
  logic [15:0] O0, O1, O2, O3;
  logic [3:0]  OV;
  logic [3:0]  ACK;
  logic [2:0]  CNT;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        iv;
    logic [1:0]  s;
    logic [15:0] i;
    logic [3:0]  ack;
    logic [15:0] e0, e1, e2, e3;
    logic [3:0]  eov;
    logic [2:0]  ecnt;
    logic        eir;
  } vec_t;

  vec_t tbl[16];

  demux1_4_16bits_reg #(.WIDTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .I(I), .S(S), .IV(IV), .IR(IR),
    .O0(O0), .O1(O1), .O2(O2), .O3(O3), .OV(OV), .ACK(ACK), .CNT(CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3,
                           input logic [3:0] eov, input logic [2:0] ecnt, input logic eir);
    check({tag, "_O0"}, 32'(O0), 32'(e0));
    check({tag, "_O1"}, 32'(O1), 32'(e1));
    check({tag, "_O2"}, 32'(O2), 32'(e2));
    check({tag, "_O3"}, 32'(O3), 32'(e3));
    check({tag, "_OV"}, 32'(OV), 32'(eov));
    check({tag, "_CNT"}, 32'(CNT), 32'(ecnt));
    check({tag, "_IR"}, 32'(IR), 32'(eir));
  endtask

  function automatic vec_t mk(input logic iv, input logic [1:0] s, input logic [15:0] i,
                              input logic [3:0] ack, input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3,
                              input logic [3:0] eov, input logic [2:0] ecnt, input logic eir);
    vec_t v;
    v.iv = iv; v.s = s; v.i = i; v.ack = ack;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    v.eov = eov; v.ecnt = ecnt; v.eir = eir;
    return v;
  endfunction

  task automatic apply(input logic iv, input logic [1:0] s, input logic [15:0] i, input logic [3:0] ack);
    @(negedge CLK);
    IV = iv; S = s; I = i; ACK = ack;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // fill, idle, backpressure, ack release, cross-slot and same-slot ack, spurious ack
    tbl[0]  = mk(1, 0, 16'h1122, 4'b0000, 16'h1122, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 1, 0);
    tbl[1]  = mk(1, 1, 16'h3344, 4'b0000, 16'h1122, 16'h3344, 16'h0000, 16'h0000, 4'b0011, 2, 0);
    tbl[2]  = mk(1, 2, 16'h5566, 4'b0000, 16'h1122, 16'h3344, 16'h5566, 16'h0000, 4'b0111, 3, 0);
    tbl[3]  = mk(1, 3, 16'h7788, 4'b0000, 16'h1122, 16'h3344, 16'h5566, 16'h7788, 4'b1111, 4, 0);
    tbl[4]  = mk(0, 0, 16'hFFFF, 4'b0000, 16'h1122, 16'h3344, 16'h5566, 16'h7788, 4'b1111, 4, 0);
    tbl[5]  = mk(1, 2, 16'hAAAA, 4'b0000, 16'h1122, 16'h3344, 16'h5566, 16'h7788, 4'b1111, 4, 0);
    tbl[6]  = mk(1, 2, 16'hAAAA, 4'b0000, 16'h1122, 16'h3344, 16'h5566, 16'h7788, 4'b1111, 4, 0);
    tbl[7]  = mk(1, 2, 16'hAAAA, 4'b0000, 16'h1122, 16'h3344, 16'h5566, 16'h7788, 4'b1111, 4, 0);
    tbl[8]  = mk(1, 2, 16'hAAAA, 4'b0100, 16'h1122, 16'h3344, 16'h5566, 16'h7788, 4'b1011, 3, 1);
    tbl[9]  = mk(1, 2, 16'hAAAA, 4'b0000, 16'h1122, 16'h3344, 16'hAAAA, 16'h7788, 4'b1111, 4, 0);
    tbl[10] = mk(0, 3, 16'h0000, 4'b1101, 16'h1122, 16'h3344, 16'hAAAA, 16'h7788, 4'b0010, 1, 1);
    tbl[11] = mk(1, 3, 16'hBEEF, 4'b0010, 16'h1122, 16'h3344, 16'hAAAA, 16'hBEEF, 4'b1000, 1, 0);
    tbl[12] = mk(1, 3, 16'h1234, 4'b1000, 16'h1122, 16'h3344, 16'hAAAA, 16'hBEEF, 4'b0000, 0, 1);
    tbl[13] = mk(1, 3, 16'h1234, 4'b0000, 16'h1122, 16'h3344, 16'hAAAA, 16'h1234, 4'b1000, 1, 0);
    tbl[14] = mk(1, 0, 16'h5A5A, 4'b1000, 16'h5A5A, 16'h3344, 16'hAAAA, 16'h1234, 4'b0001, 1, 0);
    tbl[15] = mk(0, 1, 16'hFFFF, 4'b1111, 16'h5A5A, 16'h3344, 16'hAAAA, 16'h1234, 4'b0000, 0, 1);

    RST_N = 1'b0; IV = 1'b1; S = 2'd0; I = 16'hFFFF; ACK = 4'b0000;
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset", 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 3'd0, 1'b1);
    @(negedge CLK);
    RST_N = 1'b1; IV = 1'b0;

    for (int n = 0; n < 16; n++) begin
      apply(tbl[n].iv, tbl[n].s, tbl[n].i, tbl[n].ack);
      check_all($sformatf("v%0d", n), tbl[n].e0, tbl[n].e1, tbl[n].e2, tbl[n].e3,
                tbl[n].eov, tbl[n].ecnt, tbl[n].eir);
    end

    // all slots full: IR low for every select, one ACK reopens only its slot
    for (int k = 0; k < 4; k++) apply(1, 2'(k), 16'h0100 + 16'(k), 4'b0000);
    IV = 1'b0;
    for (int k = 0; k < 4; k++) begin
      S = 2'(k);
      #1;
      check($sformatf("full_IR_s%0d", k), 32'(IR), 32'd0);
    end
    apply(0, 1, 16'h0000, 4'b0010);
    for (int k = 0; k < 4; k++) begin
      S = 2'(k);
      #1;
      check($sformatf("ack1_IR_s%0d", k), 32'(IR), (k == 1) ? 32'd1 : 32'd0);
    end
    check("ack1_CNT", 32'(CNT), 32'd3);
    apply(1, 1, 16'h0101, 4'b0000);
    check("refill_OV", 32'(OV), 32'hF);

    // asynchronous reset between edges with every slot full
    #2;
    IV = 1'b1; S = 2'd0; I = 16'hDEAD;
    RST_N = 1'b0;
    #1;
    check_all("areset", 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 3'd0, 1'b1);
    @(posedge CLK);
    #1;
    check_all("areset_hold", 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 3'd0, 1'b1);
    @(negedge CLK);
    RST_N = 1'b1; IV = 1'b1; S = 2'd2; I = 16'hCAFE;
    @(posedge CLK);
    #1;
    check_all("post_reset", 16'h0, 16'h0, 16'hCAFE, 16'h0, 4'b0100, 3'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
